// File: rtl/alu_pkg.sv
// Shared types for the ALU operand staging logic: default operand width,
// ALU control code, the control half of the payload and the skid FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef logic [2:0] aluop_t;

    // Control fields travelling with the operands. The operands themselves
    // are width-parameterised and packed alongside this struct in the top.
    typedef struct packed {
        logic   alusrc;
        aluop_t aluop;
    } alu_ctl_t;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/payload_reg.sv
// Enable-loaded payload register with asynchronous active-low clear.
module payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when load is high; clear to zero while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_operand_skid.sv
// Two-entry skid buffer between register read and the ALU operand muxes.
// The main register drives out_*; the skid register absorbs one extra entry
// so in_ready can be a pure decode of the state register.
//
// Handshake: an entry moves on a port at a rising clk edge when valid and
// ready are both 1. out_valid and in_ready depend only on the state register;
// the presented payload never changes while out_valid=1 and out_ready=0.
module alu_operand_skid
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_alusrc,
    input  aluop_t           in_aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_imm,
    output logic             out_alusrc,
    output aluop_t           out_aluop,
    output skid_state_e      dbg_state
);

    localparam int PW = 3 * WIDTH + $bits(alu_ctl_t);

    skid_state_e   state, state_next;
    logic          main_load, skid_load, main_from_skid;
    logic          accept, consume;
    alu_ctl_t      in_ctl, out_ctl;
    logic [PW-1:0] in_pl, main_d, main_q, skid_q;

    assign in_ctl.alusrc = in_alusrc;
    assign in_ctl.aluop  = in_aluop;
    assign in_pl         = {in_a, in_b, in_imm, in_ctl};

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign dbg_state = state;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // State register, cleared to EMPTY asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and register load enables; flush overrides everything.
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !consume) begin
                        state_next = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (consume && !accept) begin
                        state_next = ST_EMPTY;
                    end else if (accept && consume) begin
                        main_load  = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_next     = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    payload_reg #(.W(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    payload_reg #(.W(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_pl),
        .q     (skid_q)
    );

    assign {out_a, out_b, out_imm, out_ctl} = main_q;
    assign out_alusrc = out_ctl.alusrc;
    assign out_aluop  = out_ctl.aluop;

endmodule

// File: doc/alu_operand_skid.md
ALU_OPERAND_SKID -- requirements
Module: alu_operand_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand data width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-005 SHALL have port in_valid  input  1  upstream (register-read stage) offers an entry.
REQ-006 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-007 SHALL have port in_a, in_b, in_imm  input  WIDTH each  register operands and extended immediate.
REQ-008 SHALL have port in_alusrc  input  1  operand-B source select (1 = immediate).
REQ-009 SHALL have port in_aluop  input  3  ALU control code.
REQ-010 SHALL have port out_valid  output  1  entry presented to ALU input muxes.
REQ-011 SHALL have port out_ready  input  1  ALU stage consumes the presented entry.
REQ-012 SHALL have ports out_a, out_b, out_imm (WIDTH), out_alusrc (1), out_aluop (3)  output  registered payload feeding the ALU operand 2-to-1 select.

Function
REQ-013 SHALL transfer on a port when valid and ready are both 1 at a rising clk edge.
REQ-014 SHALL hold two payload registers: main (drives out_*) and skid; states EMPTY, ONE, TWO.
REQ-015 SHALL drive out_valid = 1 in ONE and TWO, 0 in EMPTY.
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO, decoded from state register only (no combinational path from out_ready).
REQ-017 EMPTY: accept -> ONE, payload into main; else stay.
REQ-018 ONE: accept and no consume -> TWO, payload into skid; consume and no accept -> EMPTY; accept and consume -> ONE, payload into main; neither -> stay.
REQ-019 TWO: consume -> ONE, skid moves to main same edge; no consume -> stay; no accept possible.
REQ-020 SHALL keep all out_* payload bits stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL preserve entry order; no entry duplicated or dropped except by flush.
REQ-022 SHALL on flush = 1 go to EMPTY at the next edge, discarding main, skid and any simultaneous input transfer; flush overrides all other events.
REQ-023 SHALL pass payload bits unmodified; latency in_ -> out_ is exactly 1 cycle when EMPTY and no stall.
REQ-024 SHALL sustain one transfer per cycle while out_ready stays 1.

Reset
REQ-025 SHALL, while reset = 0, force state EMPTY asynchronously: out_valid = 0, in_ready = 1, all out_* payload = 0, skid register = 0.
REQ-026 SHALL, on reset assertion mid-transfer, discard all held entries; first possible accept is the first rising edge with reset = 1.
REQ-027 SHALL release reset without glitching out_valid (stays 0 until an accept).

Structure
REQ-028 SHALL take WIDTH default, ALU-op 3-bit typedef, payload struct type and state enum from shared package alu_pkg.
REQ-029 SHALL implement each payload register as instance of sub-module payload_reg (enable-loaded, async active-low clear), two instances.
REQ-030 SHALL contain no combinational path from in_* or out_ready to in_ready or out_*.

Verification
REQ-031 Reset: reset = 0 with in_valid = 1, in_a = 0x55 -> out_valid = 0, in_ready = 1, out_a = 0 throughout.
REQ-032 Stream: out_ready = 1, 4 entries in_a = 1,2,3,4 back-to-back -> out_a = 1,2,3,4 on consecutive cycles, 1-cycle latency.
REQ-033 Stall: out_ready = 0, send in_a = 0xA then 0xB -> in_ready = 0 after 2nd accept, out_a = 0xA stable; raise out_ready -> out_a = 0xA then 0xB, in_ready returns 1 after first consume.
REQ-034 Flush: state TWO, flush = 1 with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, input entry not delivered.
REQ-035 Async reset mid-stall: state TWO, pulse reset = 0 between edges -> out_valid = 0 immediately, no entry emitted afterwards.
REQ-036 Random: random in_valid/out_ready/flush for 10000 cycles -> scoreboard order match, no loss without flush, payload stable under stall.
